seqchk: RTL
===========

Name: seqchk

Overview:
- Receiving-end counterpart of the sequence generator: consumes a sampled term stream and checks it against the recurrence a(n) = a(n-2) + a(n-3), seeded 0, 1, 1 (stream 0,1,1,1,2,2,3,4,5,7,9,12,...).
- Hunts for the sequence start, locks after consecutive matches, flags the first mismatch stickily, and counts matched terms and errors.
- Sits downstream of the generator, or of any link carrying its output, as a self-check/BIST monitor.

Parameters:
- WIDTH, 32, term width in bits; all arithmetic is modulo 2^WIDTH.
- LOCK_LEN, 4, consecutive matched terms (including the initial 0) required to assert locked_o; legal range 1..255.
- CNT_W, 32, width of term_cnt_o.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- seq_valid_i  input  1  seq_i carries a term this cycle.
- seq_i  input  WIDTH  received term.
- resync_i  input  1  leave ERROR/CHECK and return to HUNT.
- locked_o  output  1  LOCK_LEN consecutive matches seen since the last HUNT exit.
- match_o  output  1  one-cycle pulse: previous-cycle sample matched.
- err_o  output  1  sticky mismatch flag.
- expected_o  output  WIDTH  term the checker expects next (debug).
- term_cnt_o  output  CNT_W  matched terms since the last HUNT exit; wraps.
- err_cnt_o  output  8  mismatches since reset; saturates at 255.

Behaviour:
- Reset (sync, active-high): state=HUNT; predictor p0=0, p1=1, p2=1; locked_o=0, match_o=0, err_o=0, term_cnt_o=0, err_cnt_o=0, run counter=0; expected_o=p0=0.
- Predictor: expected_o=p0. On advance: p0<=p1, p1<=p2, p2<=p0+p1, truncated to WIDTH. On reseed: load 0,1,1.
- A sample is accepted only when seq_valid_i=1. Cycles with seq_valid_i=0 change nothing, and match_o returns to 0.
- All status outputs are registered: the response appears exactly 1 cycle after the accepted sample.
- HUNT:
  - sample==0: advance predictor, term_cnt_o<=1, run<=1, match_o pulse, go CHECK.
  - otherwise discard, remain in HUNT, predictor stays seeded.
  - If LOCK_LEN=1, locked_o<=1 on this transition.
- CHECK, sample==expected_o:
  - advance predictor, term_cnt_o++, match_o pulse, run++ (saturate at LOCK_LEN).
  - locked_o<=1 in the same update in which run reaches LOCK_LEN.
- CHECK, sample!=expected_o:
  - go ERROR; err_o<=1, locked_o<=0, err_cnt_o++ (saturating), match_o=0, predictor frozen.
- ERROR: all samples are ignored; no further err_cnt_o increments; state is held until resync_i.
- resync_i=1 (any state): next state HUNT, predictor reseeded, locked_o<=0, run<=0, term_cnt_o<=0.
  - err_o and err_cnt_o are retained; only reset clears them.
  - resync_i has priority over a simultaneous valid sample, which is discarded.
- Reset has priority over everything, including mid-stream and mid-ERROR.
- Wrap-around: terms beyond 2^WIDTH compare modulo 2^WIDTH, so WIDTH=1 checks parity only. term_cnt_o wraps silently.

Decomposition:
- Package seqchk_pkg holds:
  - state enum {HUNT, CHECK, ERROR} (2 bits);
  - seed constants SEED0=0, SEED1=1, SEED2=1;
  - ERR_CNT_W=8.
- One sub-module, seqchk_pred: three-register recurrence with advance/reseed controls and WIDTH parameter, outputting p0. The top-level holds the FSM, counters and flags.

Test Plan:
- Lock: after reset, feed 0,1,1,1,2,2,3,4 back-to-back -> match_o each cycle, locked_o=1 one cycle after the 4th term (LOCK_LEN=4), term_cnt_o=8, err_o=0.
- HUNT discard: feed 5,9,0,1,1 -> 5 and 9 produce no match_o and term_cnt_o stays 0; 0,1,1 match; term_cnt_o=3, locked_o=0.
- Mismatch: feed 0,1,1,1,2,3 -> err_o=1 and err_cnt_o=1 one cycle after the 3; locked_o drops; further samples (e.g. 3,4) leave err_cnt_o=1.
- Resync: from ERROR, pulse resync_i with seq_valid_i=1, seq_i=0 -> sample discarded, state HUNT. Then 0,1,1 -> term_cnt_o=3, err_o remains 1.
- Gaps and wrap: WIDTH=4, insert idle cycles between terms and run past 12,16(->0),21(->5),28(->12) -> modulo compare passes, no error, idle cycles leave outputs unchanged except match_o=0.
- Reset mid-stream: assert reset while locked in CHECK -> next cycle all outputs at reset values, expected_o=0, err_cnt_o=0.

Source files
------------

// File: rtl/seqchk_pkg.sv
// rtl/seqchk_pkg.sv - shared types and constants for the sequence checker
package seqchk_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam int unsigned SEED0 = 0;
    localparam int unsigned SEED1 = 1;
    localparam int unsigned SEED2 = 1;

    localparam int ERR_CNT_W = 8;
    localparam int RUN_W     = 8;

endpackage

// File: rtl/seqchk_pred.sv
// rtl/seqchk_pred.sv - three-term predictor for a(n) = a(n-2) + a(n-3)
module seqchk_pred
    import seqchk_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             reseed,
    output logic [WIDTH-1:0] p0
);

    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] p2;

    always_ff @(posedge clk) begin
        if (reset || reseed) begin
            p0 <= WIDTH'(SEED0);
            p1 <= WIDTH'(SEED1);
            p2 <= WIDTH'(SEED2);
        end else if (advance) begin
            p0 <= p1;
            p1 <= p2;
            p2 <= p0 + p1;
        end
    end

endmodule

// File: rtl/seqchk.sv
// rtl/seqchk.sv - hunts, locks onto and checks the a(n)=a(n-2)+a(n-3) term stream
module seqchk
    import seqchk_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LOCK_LEN = 4,
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seq_valid_i,
    input  logic [WIDTH-1:0]     seq_i,
    input  logic                 resync_i,
    output logic                 locked_o,
    output logic                 match_o,
    output logic                 err_o,
    output logic [WIDTH-1:0]     expected_o,
    output logic [CNT_W-1:0]     term_cnt_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    state_t           state;
    state_t           state_nxt;
    logic             advance;
    logic             reseed;
    logic             hit;
    logic             miss;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_inc;

    seqchk_pred #(.WIDTH(WIDTH)) u_pred (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .reseed  (reseed),
        .p0      (expected_o)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= HUNT;
        else       state <= state_nxt;
    end

    // In HUNT the predictor is always seeded, so expected_o is 0 there.
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        reseed    = 1'b0;
        hit       = 1'b0;
        miss      = 1'b0;
        if (resync_i) begin
            state_nxt = HUNT;
            reseed    = 1'b1;
        end else if (seq_valid_i) begin
            case (state)
                HUNT: begin
                    if (seq_i == '0) begin
                        hit       = 1'b1;
                        advance   = 1'b1;
                        state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (seq_i == expected_o) begin
                        hit     = 1'b1;
                        advance = 1'b1;
                    end else begin
                        miss      = 1'b1;
                        state_nxt = ERROR;
                    end
                end
                ERROR: ;
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign run_inc = (run_q == RUN_W'(LOCK_LEN)) ? run_q : run_q + 1'b1;

    // Run and term counters are zero whenever HUNT is entered, so the HUNT
    // hit needs no special case.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_o   <= 1'b0;
            match_o    <= 1'b0;
            err_o      <= 1'b0;
            term_cnt_o <= '0;
            err_cnt_o  <= '0;
            run_q      <= '0;
        end else begin
            match_o <= hit;
            if (resync_i) begin
                locked_o   <= 1'b0;
                run_q      <= '0;
                term_cnt_o <= '0;
            end else if (hit) begin
                term_cnt_o <= term_cnt_o + 1'b1;
                run_q      <= run_inc;
                if (run_inc == RUN_W'(LOCK_LEN)) locked_o <= 1'b1;
            end else if (miss) begin
                err_o    <= 1'b1;
                locked_o <= 1'b0;
                if (err_cnt_o != {ERR_CNT_W{1'b1}}) err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end

endmodule
